// File: rtl/decim_if.sv
// Sample-stream and memory-block control bundle for the polyphase decimator sequencer.
// The slave modport is the sequencer; the master modport is the sample source / memory side.
interface decim_if #(
  parameter int SAMPLE_SIZE = 16,
  parameter int AW          = 8
);
  logic                   s_valid;
  logic [SAMPLE_SIZE-1:0] s_in;
  logic                   c_load;
  logic                   cfg_ready;
  logic [SAMPLE_SIZE-1:0] s_wdata;
  logic                   sample_we;
  logic                   sample_en_0;
  logic                   sample_en_1;
  logic                   coeff_en;
  logic [AW-1:0]          sample_addr;
  logic [AW-1:0]          coeff_addr;
  logic                   mac_bank;
  logic                   mac_first;
  logic                   mac_acc;
  logic                   out_valid;
  logic                   overrun;

  modport master (
    output s_valid, s_in, c_load,
    input  cfg_ready, s_wdata, sample_we, sample_en_0, sample_en_1, coeff_en,
           sample_addr, coeff_addr, mac_bank, mac_first, mac_acc, out_valid, overrun
  );

  modport slave (
    input  s_valid, s_in, c_load,
    output cfg_ready, s_wdata, sample_we, sample_en_0, sample_en_1, coeff_en,
           sample_addr, coeff_addr, mac_bank, mac_first, mac_acc, out_valid, overrun
  );
endinterface

// File: rtl/decim_scheduler.sv
// Polyphase decimator sequencer: buffers incoming samples, writes them into the circular
// sample RAMs and runs one MAC_SIZE-cycle address sweep after every D samples.
module decim_scheduler #(
  parameter int MAC_SIZE    = 255,
  parameter int D           = 100,
  parameter int SAMPLE_SIZE = 16
) (
  input logic    clk,
  input logic    rst,
  decim_if.slave bus
);
  localparam int AW = $clog2(MAC_SIZE);
  localparam int PW = $clog2(D);
  localparam int SW = AW + 1;
  localparam logic [AW-1:0] LAST_TAP   = AW'(MAC_SIZE - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(D - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, next_state;
  logic [AW-1:0]          wp, tap, base, rd_addr;
  logic [PW-1:0]          phase;
  logic                   start_req, parity;
  logic [SAMPLE_SIZE-1:0] fifo_mem [4];
  logic [1:0]             head, tail;
  logic [2:0]             count;
  logic                   overrun_q, first_q, acc_q, last_q, out_valid_q, bank_q;
  logic                   run, at_last, do_start, do_pop, do_push;
  logic [SW-1:0]          rd_sum;

  assign run      = (state == RUN);
  assign at_last  = (tap == LAST_TAP);
  // A pending pass wins over draining so new samples cannot overwrite its taps.
  assign do_start = (state == IDLE) && start_req && !bus.c_load;
  assign do_pop   = (state == IDLE) && !do_start && (count != 3'd0);
  assign do_push  = bus.s_valid && (count != 3'd4);

  // Newest sample first: (base - 1 - tap) mod MAC_SIZE without a divider.
  assign rd_sum  = {1'b0, base} + SW'(MAC_SIZE - 1) - {1'b0, tap};
  assign rd_addr = (rd_sum >= SW'(MAC_SIZE)) ? AW'(rd_sum - SW'(MAC_SIZE)) : AW'(rd_sum);

  // NOTE: clocked state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (do_start) next_state = RUN;
      RUN:  if (at_last)  next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    bus.cfg_ready   = 1'b0;
    bus.s_wdata     = '0;
    bus.sample_we   = 1'b0;
    bus.sample_en_0 = 1'b0;
    bus.sample_en_1 = 1'b0;
    bus.coeff_en    = 1'b0;
    bus.sample_addr = '0;
    bus.coeff_addr  = '0;
    unique case (state)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        bus.coeff_en  = bus.c_load;
        if (do_pop) begin
          bus.s_wdata     = fifo_mem[head];
          bus.sample_we   = 1'b1;
          bus.sample_en_0 = 1'b1;
          bus.sample_en_1 = 1'b1;
          bus.sample_addr = wp;
        end
      end
      RUN: begin
        bus.sample_addr = rd_addr;
        bus.coeff_addr  = tap;
        bus.coeff_en    = 1'b1;
        bus.sample_en_0 = ~parity;
        bus.sample_en_1 = parity;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp          <= '0;
      phase       <= '0;
      tap         <= '0;
      base        <= '0;
      start_req   <= 1'b0;
      parity      <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      overrun_q   <= 1'b0;
      first_q     <= 1'b0;
      acc_q       <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      bank_q      <= 1'b0;
    end else begin
      if (do_push) tail <= tail + 2'd1;
      if (do_pop)  head <= head + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
      if (bus.s_valid && count == 3'd4) overrun_q <= 1'b1;

      if (do_pop) begin
        wp <= (wp == LAST_TAP) ? '0 : wp + AW'(1);
        if (phase == LAST_PHASE) begin
          phase     <= '0;
          start_req <= 1'b1;
        end else begin
          phase <= phase + PW'(1);
        end
      end

      if (do_start) begin
        base      <= wp;
        tap       <= '0;
        start_req <= 1'b0;
      end else if (run) begin
        tap <= at_last ? '0 : tap + AW'(1);
      end
      if (run && at_last) parity <= ~parity;

      // MAC strobes trail the addresses by the 1-cycle RAM read latency.
      first_q     <= run && (tap == '0);
      acc_q       <= run && (tap != '0);
      last_q      <= run && at_last;
      out_valid_q <= last_q;
      bank_q      <= run && parity;
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only read after being written, and
  // leaving it out keeps the array in plain registers/RAM without reset muxing.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[tail] <= bus.s_in;
  end

  assign bus.mac_first = first_q;
  assign bus.mac_acc   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mac_bank  = bank_q;
  assign bus.overrun   = overrun_q;
endmodule
